// File: rtl/rst_sync_gen_pkg.sv
// Shared types and constants for the reset generator: state encodings,
// default timing constants and the counter-width helper.
package rst_sync_gen_pkg;

    localparam logic [2:0] ST_ASSERT  = 3'd0;
    localparam logic [2:0] ST_STRETCH = 3'd1;
    localparam logic [2:0] ST_RUN     = 3'd2;
    localparam logic [2:0] ST_SW_HOLD = 3'd3;
    localparam logic [2:0] ST_SW_ACK  = 3'd4;

    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_STRETCH_CYCLES = 16;
    localparam int DEF_SW_RST_CYCLES  = 8;

    typedef enum logic [2:0] {
        S_ASSERT  = ST_ASSERT,
        S_STRETCH = ST_STRETCH,
        S_RUN     = ST_RUN,
        S_SW_HOLD = ST_SW_HOLD,
        S_SW_ACK  = ST_SW_ACK
    } state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_sync_gen_if.sv
// Software-reset handshake and reset-status signals of one clock domain.
interface rst_sync_gen_if;
    logic sw_rst_req;
    logic sw_rst_ack;
    logic sync_rst;
    logic rst_done;
    logic rst_busy;

    modport master (
        output sw_rst_req,
        input  sw_rst_ack,
        input  sync_rst,
        input  rst_done,
        input  rst_busy
    );

    modport slave (
        input  sw_rst_req,
        output sw_rst_ack,
        output sync_rst,
        output rst_done,
        output rst_busy
    );
endinterface

// File: rtl/rst_sync_chain.sv
// Release synchroniser: a shift chain of ones, cleared asynchronously by rst.
// Kept as its own module so CDC constraints can target exactly these flops.
module rst_sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic rel_sync
);
    logic [SYNC_STAGES-1:0] chain_q;
    logic [SYNC_STAGES-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[SYNC_STAGES-2:0], 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign rel_sync = chain_q[SYNC_STAGES-1];
endmodule

// File: rtl/rst_sync_gen.sv
// Root of a clock domain's reset tree: async-assert / sync-release reset with
// a stretch period and a software-requested reset via a 4-phase handshake.
module rst_sync_gen
    import rst_sync_gen_pkg::*;
#(
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int STRETCH_CYCLES = DEF_STRETCH_CYCLES,
    parameter int SW_RST_CYCLES  = DEF_SW_RST_CYCLES
) (
    input  logic           clk,
    input  logic           rst,
    rst_sync_gen_if.slave  rif
);
    localparam int CNT_W = $clog2(max2(STRETCH_CYCLES, SW_RST_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] SW_LAST      = CNT_W'(SW_RST_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync_rst_q, sync_rst_d;
    logic             ack_q, ack_d;
    logic             done_q, done_d;
    logic             rel_sync;

    rst_sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_chain (
        .clk      (clk),
        .rst_n    (rst),
        .rel_sync (rel_sync)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sync_rst_d = sync_rst_q;
        ack_d      = ack_q;
        done_d     = 1'b0;
        unique case (state_q)
            S_ASSERT: begin
                sync_rst_d = 1'b1;
                ack_d      = 1'b0;
                if (rel_sync) begin
                    state_d = S_STRETCH;
                    cnt_d   = '0;
                end
            end
            S_STRETCH: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == STRETCH_LAST) begin
                    state_d    = S_RUN;
                    cnt_d      = '0;
                    sync_rst_d = 1'b0;
                    done_d     = 1'b1;
                end
            end
            S_RUN: begin
                if (rif.sw_rst_req) begin
                    state_d    = S_SW_HOLD;
                    cnt_d      = '0;
                    sync_rst_d = 1'b1;
                end
            end
            S_SW_HOLD: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == SW_LAST) begin
                    state_d = S_SW_ACK;
                    cnt_d   = '0;
                    ack_d   = 1'b1;
                end
            end
            S_SW_ACK: begin
                // Release only after the requester drops its level (4-phase).
                if (!rif.sw_rst_req) begin
                    state_d = S_STRETCH;
                    cnt_d   = '0;
                    ack_d   = 1'b0;
                end
            end
            default: begin
                state_d    = S_ASSERT;
                cnt_d      = '0;
                sync_rst_d = 1'b1;
                ack_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_ASSERT;
            cnt_q      <= '0;
            sync_rst_q <= 1'b1;
            ack_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sync_rst_q <= sync_rst_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
        end
    end

    assign rif.sync_rst   = sync_rst_q;
    assign rif.sw_rst_ack = ack_q;
    assign rif.rst_done   = done_q;
    assign rif.rst_busy   = (state_q != S_RUN);
endmodule

// File: tb/tb_rst_sync_gen.sv
// Directed bench for rst_sync_gen: default instance plus a SYNC_STAGES=3,
// STRETCH_CYCLES=1 instance sharing clock and reset.
module tb_rst_sync_gen;
    import rst_sync_gen_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    rst_sync_gen_if rif ();
    rst_sync_gen_if rif2 ();

    rst_sync_gen dut (
        .clk (clk),
        .rst (rst),
        .rif (rif.slave)
    );

    rst_sync_gen #(
        .SYNC_STAGES    (3),
        .STRETCH_CYCLES (1),
        .SW_RST_CYCLES  (8)
    ) dut2 (
        .clk (clk),
        .rst (rst),
        .rif (rif2.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %0d", tag, got);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int highs;
        int dones;
        rif.sw_rst_req  = 1'b0;
        rif2.sw_rst_req = 1'b0;
        rst = 1'b0;

        // Power-on
        repeat (5) tick();
        check("por_sync_rst", 32'(rif.sync_rst), 1);
        check("por_ack", 32'(rif.sw_rst_ack), 0);
        check("por_done", 32'(rif.rst_done), 0);
        check("por_busy", 32'(rif.rst_busy), 1);
        release_rst();
        highs = 0;
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (rif.sync_rst) highs++;
            if (k == 4) check("p3s1_edge4_sync_rst", 32'(rif2.sync_rst), 1);
            if (k == 5) begin
                check("p3s1_edge5_sync_rst", 32'(rif2.sync_rst), 0);
                check("p3s1_edge5_done", 32'(rif2.rst_done), 1);
            end
        end
        check("por_high_edges_1_18", 32'(highs), 18);
        tick();
        check("por_edge19_sync_rst", 32'(rif.sync_rst), 0);
        check("por_edge19_done", 32'(rif.rst_done), 1);
        check("por_edge19_busy", 32'(rif.rst_busy), 0);
        tick();
        check("por_edge20_done", 32'(rif.rst_done), 0);
        check("por_edge20_sync_rst", 32'(rif.sync_rst), 0);

        // Software reset handshake
        @(negedge clk);
        rif.sw_rst_req = 1'b1;
        tick();
        check("sw_E_sync_rst", 32'(rif.sync_rst), 1);
        check("sw_E_busy", 32'(rif.rst_busy), 1);
        repeat (7) tick();
        check("sw_E7_ack", 32'(rif.sw_rst_ack), 0);
        tick();
        check("sw_E8_ack", 32'(rif.sw_rst_ack), 1);
        @(negedge clk);
        rif.sw_rst_req = 1'b0;
        tick();
        check("sw_F_ack", 32'(rif.sw_rst_ack), 0);
        check("sw_F_sync_rst", 32'(rif.sync_rst), 1);
        repeat (15) tick();
        check("sw_F15_sync_rst", 32'(rif.sync_rst), 1);
        tick();
        check("sw_F16_sync_rst", 32'(rif.sync_rst), 0);
        check("sw_F16_done", 32'(rif.rst_done), 1);
        tick();
        check("sw_F17_done", 32'(rif.rst_done), 0);

        // Async assert while ack is high
        @(negedge clk);
        rif.sw_rst_req = 1'b1;
        repeat (9) tick();
        check("ack_before_async", 32'(rif.sw_rst_ack), 1);
        #1 rst = 1'b0;
        #1;
        check("async_ack", 32'(rif.sw_rst_ack), 0);
        check("async_sync_rst", 32'(rif.sync_rst), 1);
        check("async_state", 32'(dut.state_q), 32'(S_ASSERT));
        rif.sw_rst_req = 1'b0;

        // Reset re-asserted mid-stretch
        repeat (2) tick();
        release_rst();
        repeat (10) tick();
        rst = 1'b0;
        #1;
        check("mid_sync_rst", 32'(rif.sync_rst), 1);
        check("mid_state", 32'(dut.state_q), 32'(S_ASSERT));
        repeat (3) tick();
        release_rst();
        highs = 0;
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (rif.sync_rst) highs++;
        end
        check("mid_high_edges_1_18", 32'(highs), 18);
        tick();
        check("mid_edge19_sync_rst", 32'(rif.sync_rst), 0);

        // Request held through power-on stretch
        @(negedge clk);
        rst = 1'b0;
        rif.sw_rst_req = 1'b1;
        repeat (2) tick();
        release_rst();
        dones = 0;
        for (int k = 1; k <= 19; k++) begin
            tick();
            if (rif.rst_done) dones++;
        end
        check("early_edge19_sync_rst", 32'(rif.sync_rst), 0);
        check("early_edge19_state", 32'(dut.state_q), 32'(S_RUN));
        tick();
        if (rif.rst_done) dones++;
        check("early_edge20_state", 32'(dut.state_q), 32'(S_SW_HOLD));
        check("early_edge20_sync_rst", 32'(rif.sync_rst), 1);
        check("early_done_pulses", 32'(dones), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
